// File: rtl/pixel_readout_pkg.sv
// pixel_readout_pkg: shared sensor geometry (PixelSensorConfig), output FSM state and row-tag types.
package PixelSensorConfig;
  localparam int PIXEL_ARRAY_WIDTH = 2;
  localparam int PIXEL_ARRAY_HEIGHT = 2;
  localparam int PIXEL_BITS = 8;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  typedef enum logic {IDLE, STREAM} out_state_e;
  typedef logic [width_of(PIXEL_ARRAY_HEIGHT)-1:0] row_tag_t;
endpackage

// File: rtl/pixel_readout_row_fifo.sv
// RowFifo: row buffer of DEPTH entries; exposes head and the entry behind it so the
// reader can move to the next row in the same cycle it pops the head.
module RowFifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W-1:0] next_data,
  output logic              full,
  output logic              empty,
  output logic              multi
);
  import PixelSensorConfig::*;
  localparam int PTR_W = width_of(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_wr, do_rd;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = count_q == CNT_W'(DEPTH);
  assign empty = count_q == '0;
  assign multi = count_q > CNT_W'(1);
  assign head_data = mem_q[rd_ptr_q];
  assign next_data = mem_q[inc(rd_ptr_q)];
  always_comb begin
    do_rd = rd_en && !empty;
    do_wr = wr_en && (!full || do_rd);
    wr_ptr_d = do_wr ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? inc(rd_ptr_q) : rd_ptr_q;
    count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) if (do_wr) mem_q[wr_ptr_q] <= wr_data;
endmodule

// File: rtl/pixel_readout.sv
// pixel_readout: captures sensor rows into RowFifo and serializes them as a ready/valid pixel stream.
// PIXEL_READOUT_GRAY_DECODE_EN: Gray-to-binary decode each pixel on OUT_DATA (no added latency).
module pixel_readout #(
  parameter int PIXEL_ARRAY_WIDTH = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
  parameter int PIXEL_ARRAY_HEIGHT = PixelSensorConfig::PIXEL_ARRAY_HEIGHT,
  parameter int PIXEL_BITS = PixelSensorConfig::PIXEL_BITS,
  parameter int FIFO_ROWS = 2
) (
  input  logic                                                        CLK,
  input  logic                                                        RESET,
  input  logic                                                        NEW_ROW,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]                     ROW_DATA,
  input  logic                                                        FRAME_FINISHED,
  input  logic                                                        OUT_READY,
  output logic                                                        OUT_VALID,
  output logic [PIXEL_BITS-1:0]                                       OUT_DATA,
  output logic [PixelSensorConfig::width_of(PIXEL_ARRAY_WIDTH)-1:0]   OUT_COL,
  output logic [PixelSensorConfig::width_of(PIXEL_ARRAY_HEIGHT)-1:0]  OUT_ROW,
  output logic                                                        OUT_FRAME_END,
  output logic                                                        OVERFLOW
);
  import PixelSensorConfig::*;
  localparam int COL_W = width_of(PIXEL_ARRAY_WIDTH);
  localparam int ROW_W = width_of(PIXEL_ARRAY_HEIGHT);
  localparam int IDX_W = $clog2(PIXEL_ARRAY_HEIGHT + 1);
  localparam int ROW_BITS = PIXEL_ARRAY_WIDTH * PIXEL_BITS;
  localparam int ENTRY_W = ROW_W + ROW_BITS;
  out_state_e state_q, state_d;
  logic [IDX_W-1:0] row_idx_q, row_idx_d;
  logic [ROW_BITS-1:0] sreg_q, sreg_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] tag_q, tag_d;
  logic overflow_q, overflow_d;
  logic [ENTRY_W-1:0] wr_entry, head_entry, next_entry, load_entry;
  logic full, empty, multi;
  logic fire, last, pop, room, capture, load;
  logic [PIXEL_BITS-1:0] pix, pix_out;
  RowFifo #(.DATA_W(ENTRY_W), .DEPTH(FIFO_ROWS)) u_fifo (
    .clk(CLK),
    .rst_n(RESET),
    .wr_en(capture),
    .wr_data(wr_entry),
    .rd_en(pop),
    .head_data(head_entry),
    .next_data(next_entry),
    .full(full),
    .empty(empty),
    .multi(multi)
  );
  // Head stays buffered until its last pixel is accepted; a row arriving while the
  // only buffered row pops is the next one to stream.
  always_comb begin
    fire = state_q == STREAM && OUT_READY;
    last = col_q == COL_W'(PIXEL_ARRAY_WIDTH - 1);
    pop = fire && last;
    room = row_idx_q < IDX_W'(PIXEL_ARRAY_HEIGHT);
    capture = NEW_ROW && room && (!full || pop);
    wr_entry = {ROW_W'(row_idx_q), ROW_DATA};
    row_idx_d = FRAME_FINISHED ? '0 : (NEW_ROW && room) ? row_idx_q + 1'b1 : row_idx_q;
    overflow_d = overflow_q | (NEW_ROW & ~capture);
    load = (state_q == IDLE && !empty) || (pop && (multi || capture));
    load_entry = (state_q == IDLE) ? head_entry : multi ? next_entry : wr_entry;
    state_d = state_q;
    sreg_d = sreg_q;
    col_d = col_q;
    tag_d = tag_q;
    if (load) begin
      state_d = STREAM;
      sreg_d = load_entry[ROW_BITS-1:0];
      tag_d = load_entry[ENTRY_W-1 -: ROW_W];
      col_d = '0;
    end else if (fire) begin
      state_d = last ? IDLE : STREAM;
      sreg_d = sreg_q >> PIXEL_BITS;
      col_d = last ? '0 : col_q + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      row_idx_q <= '0;
      sreg_q <= '0;
      col_q <= '0;
      tag_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_idx_q <= row_idx_d;
      sreg_q <= sreg_d;
      col_q <= col_d;
      tag_q <= tag_d;
      overflow_q <= overflow_d;
    end
  end
  always_comb begin
    pix = sreg_q[PIXEL_BITS-1:0];
    pix_out = pix;
`ifdef PIXEL_READOUT_GRAY_DECODE_EN
    for (int i = 0; i < PIXEL_BITS; i++) pix_out[i] = ^(pix >> i);
`endif
  end
  assign OUT_VALID = state_q == STREAM;
  assign OUT_DATA = pix_out;
  assign OUT_COL = col_q;
  assign OUT_ROW = tag_q;
  assign OUT_FRAME_END = OUT_VALID && last && tag_q == ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  assign OVERFLOW = overflow_q;
endmodule
